// File: rtl/csr_access_unit.sv
// CSR access unit: misa, mscratch, mcycle/mcycleh, mhartid behind a
// valid/ready request port and a held response port (1-cycle latency).
// Ports: clk_i, rst_ni (sync, active-low); req_valid_i/req_ready_o,
// req_addr_i[11:0], req_op_i[1:0] (rd/wr/set/clr), req_wdata_i[31:0];
// rsp_valid_o/rsp_ready_i, rsp_rdata_o[31:0] (pre-op value), rsp_illegal_o.
module csr_access_unit #(
  parameter logic [1:0] CSR_MISA_MXL = 2'd1,
  parameter bit         RV32M        = 1'b1,
  parameter bit         RV32E        = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [31:0] MISA =
      (32'(CSR_MISA_MXL) << 30)
    | (32'(1'b1)        << 20)
    | (32'(RV32M)       << 12)
    | (32'(!RV32E)      << 8)
    | (32'(RV32E)       << 4)
    | (32'(1'b1)        << 2);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0] rdata_q;
  logic        illegal_q;
  logic [31:0] mscratch_q;
  logic [63:0] cycle_q;

  logic        accept;
  logic        sel_misa, sel_mscratch;
  logic        sel_mcycle, sel_mcycleh;
  logic        sel_mhartid;
  logic        hit, is_wr, illegal, commit;
  logic [31:0] old_val, new_val;

  assign accept = (state_q == IDLE) && req_valid_i;

  assign sel_misa     = req_addr_i == 12'h301;
  assign sel_mscratch = req_addr_i == 12'h340;
  assign sel_mcycle   = req_addr_i == 12'hB00;
  assign sel_mcycleh  = req_addr_i == 12'hB80;
  assign sel_mhartid  = req_addr_i == 12'hF14;

  assign hit = sel_misa | sel_mscratch | sel_mcycle
             | sel_mcycleh | sel_mhartid;

  assign is_wr = req_op_i != OP_RD;

  // addr[11:10]==11 marks the read-only CSR space
  assign illegal = !hit || (is_wr && (req_addr_i[11:10] == 2'b11));

  // misa is WARL: a legal write that simply has no target
  assign commit = accept && !illegal && is_wr;

  always_comb begin
    old_val = '0;
    unique case (1'b1)
      sel_misa:     old_val = MISA;
      sel_mscratch: old_val = mscratch_q;
      sel_mcycle:   old_val = cycle_q[31:0];
      sel_mcycleh:  old_val = cycle_q[63:32];
      sel_mhartid:  old_val = '0;
      default:      old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    unique case (req_op_i)
      OP_WR:   new_val = req_wdata_i;
      OP_SET:  new_val = old_val | req_wdata_i;
      OP_CLR:  new_val = old_val & ~req_wdata_i;
      default: new_val = old_val;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      mscratch_q <= '0;
      cycle_q    <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (accept) begin
        rdata_q   <= illegal ? 32'd0 : old_val;
        illegal_q <= illegal;
      end
      if (commit && sel_mscratch) mscratch_q <= new_val;
      // a counter write wins over the increment; other half holds
      if (commit && sel_mcycle)
        cycle_q <= {cycle_q[63:32], new_val};
      if (commit && sel_mcycleh)
        cycle_q <= {new_val, cycle_q[31:0]};
    end
  end

  assign req_ready_o   = state_q == IDLE;
  assign rsp_valid_o   = state_q == RESP;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_illegal_o = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: vector table plus
// hand sequences for counter carry/priority, stall and reset-in-RESP.
module tb_csr_access_unit;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_wdata = '0;

  logic        req_ready, rsp_valid, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        req_ready_e, rsp_valid_e, rsp_illegal_e;
  logic [31:0] rsp_rdata_e;

  int n_cmp = 0;
  int n_bad = 0;

  csr_access_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_op_i(req_op),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal)
  );

  csr_access_unit #(
    .CSR_MISA_MXL(2'd1), .RV32M(1'b0), .RV32E(1'b1)
  ) dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_e),
    .req_addr_i(req_addr), .req_op_i(req_op),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_e), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_e), .rsp_illegal_o(rsp_illegal_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the unit idle; returns one
  // negedge after the response handshake, unit idle again.
  task automatic do_req(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic ill,
                        output logic [31:0] rd_e);
    req_valid = 1'b1;
    req_addr  = a;
    req_op    = op;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    rd   = rsp_rdata;
    ill  = rsp_illegal;
    rd_e = rsp_rdata_e;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd, rd_e;
  logic        ill;

  initial begin
    vecs[0]  = '{12'h301, RD, 32'h0,        32'h40101104, 1'b0};
    vecs[1]  = '{12'h301, WR, 32'h0,        32'h40101104, 1'b0};
    vecs[2]  = '{12'h301, RD, 32'h0,        32'h40101104, 1'b0};
    vecs[3]  = '{12'h340, WR, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[4]  = '{12'h340, ST, 32'h0000F000, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{12'h340, CL, 32'h000000FF, 32'hDEADFEEF, 1'b0};
    vecs[6]  = '{12'h340, RD, 32'h0,        32'hDEADFE00, 1'b0};
    vecs[7]  = '{12'hF14, WR, 32'h123,      32'h0,        1'b1};
    vecs[8]  = '{12'hF14, RD, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{12'h7C0, RD, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{12'h7C0, WR, 32'h1,        32'h0,        1'b1};
    vecs[11] = '{12'hC00, RD, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{12'hF14, ST, 32'h1,        32'h0,        1'b1};
    vecs[13] = '{12'h340, RD, 32'h0,        32'hDEADFE00, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_illegal", 32'(rsp_illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].addr, vecs[i].op, vecs[i].wdata, rd, ill, rd_e);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].ill));
      if (vecs[i].addr == 12'h301 && vecs[i].op == RD)
        chk($sformatf("vec%0d_misa_e", i), rd_e, 32'h40100014);
    end

    // counter carry from low into high half
    do_req(12'hB80, WR, 32'h0, rd, ill, rd_e);
    do_req(12'hB00, WR, 32'hFFFFFFFF, rd, ill, rd_e);
    do_req(12'hB80, RD, 32'h0, rd, ill, rd_e);
    chk("carry_mcycleh", rd, 32'd1);
    do_req(12'hB00, RD, 32'h0, rd, ill, rd_e);
    chk("carry_mcycle", rd, 32'd2);

    // mcycleh write freezes low half in that cycle
    do_req(12'hB00, WR, 32'h100, rd, ill, rd_e);
    do_req(12'hB80, WR, 32'h7, rd, ill, rd_e);
    chk("mcycleh_old", rd, 32'd1);
    do_req(12'hB00, RD, 32'h0, rd, ill, rd_e);
    chk("prio_mcycle", rd, 32'h102);
    do_req(12'hB80, RD, 32'h0, rd, ill, rd_e);
    chk("prio_mcycleh", rd, 32'h7);

    // response stall with a new request held during RESP
    req_valid = 1'b1;
    req_addr  = 12'h340;
    req_op    = RD;
    @(negedge clk);
    req_op    = WR;
    req_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEADFE00);
      chk("stall_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_idle_ready", 32'(req_ready), 32'd1);
    chk("stall_idle_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("held_valid", 32'(rsp_valid), 32'd1);
    chk("held_rdata", rsp_rdata, 32'hDEADFE00);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(12'h340, RD, 32'h0, rd, ill, rd_e);
    chk("held_write", rd, 32'h55);

    // reset while a response is pending
    req_valid = 1'b1;
    req_addr  = 12'h340;
    req_op    = RD;
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rresp_valid", 32'(rsp_valid), 32'd0);
    chk("rresp_rdata", rsp_rdata, 32'd0);
    chk("rresp_illegal", 32'(rsp_illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rresp_ready", 32'(req_ready), 32'd1);
    do_req(12'hB00, RD, 32'h0, rd, ill, rd_e);
    chk("rresp_mcycle", rd, 32'd1);
    do_req(12'h340, RD, 32'h0, rd, ill, rd_e);
    chk("rresp_mscratch", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL have parameter CSR_MISA_MXL, default 2'd1, the MXL field placed in misa[31:30].
REQ-002 The block SHALL have parameter RV32M, default 1, meaning the M extension is present.
REQ-003 The block SHALL have parameter RV32E, default 0, meaning the E base is used instead of I.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req_valid_i, input, 1 bit: a CSR request is present.
REQ-007 The block SHALL have port req_ready_o, output, 1 bit: the unit accepts a request.
REQ-008 The block SHALL have port req_addr_i, input, 12 bits: the CSR address.
REQ-009 The block SHALL have port req_op_i, input, 2 bits: 00 read, 01 write, 10 set, 11 clear.
REQ-010 The block SHALL have port req_wdata_i, input, 32 bits: the write, set or clear operand.
REQ-011 The block SHALL have port rsp_valid_o, output, 1 bit: a response is present.
REQ-012 The block SHALL have port rsp_ready_i, input, 1 bit: the consumer takes the response.
REQ-013 The block SHALL have port rsp_rdata_o, output, 32 bits: the CSR value from before the operation.
REQ-014 The block SHALL have port rsp_illegal_o, output, 1 bit: the access was illegal.

Function
REQ-015 The block SHALL compute the constant MISA from the parameters:
- bit2 (C) = 1
- bit4 (E) = RV32E
- bit8 (I) = !RV32E
- bit12 (M) = RV32M
- bit20 (U) = 1
- [31:30] = CSR_MISA_MXL
- all other bits = 0
REQ-016 The block SHALL implement a two-state FSM, IDLE and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted in IDLE when req_valid_i=1; the FSM SHALL go to RESP on the next edge, so the response has 1 cycle latency.
REQ-018 In RESP, rsp_valid_o SHALL be 1, and rsp_rdata_o and rsp_illegal_o SHALL stay stable until rsp_ready_i=1; the FSM SHALL then return to IDLE on that edge.
REQ-019 There SHALL be no back-to-back accept: the minimum request spacing is 2 cycles.
REQ-020 The CSR map SHALL be:
- misa 0x301: WARL; writes are ignored and are not illegal.
- mscratch 0x340: 32-bit read/write.
- mcycle 0xB00: read/write, low 32 bits of the 64-bit cycle counter.
- mcycleh 0xB80: read/write, high 32 bits.
- mhartid 0xF14: read-only, value 0.
REQ-021 On acceptance, the new CSR value SHALL be:
- write: wdata
- set: old | wdata
- clear: old & ~wdata
REQ-022 Any address outside the map SHALL be illegal.
REQ-023 A non-read op to an address with addr[11:10]==2'b11 SHALL be illegal.
REQ-024 An illegal access SHALL return rdata 0 and SHALL modify no state.
REQ-025 The 64-bit cycle counter SHALL increment by 1 every cycle, wrapping from 2^64-1 to 0 with carry from bit 31 into bit 32.
REQ-026 A write to mcycle or mcycleh SHALL take priority over the increment in the accept cycle: the written half takes the new value and the other half holds.
REQ-027 A read of mcycle SHALL return the counter value in the accept cycle, not a later value.
REQ-028 Requests presented in RESP SHALL be neither accepted nor dropped; the requester holds them.

Reset
REQ-029 With rst_ni=0 at a clock edge, the block SHALL set:
- FSM = IDLE
- req_ready_o = 1 after release
- rsp_valid_o = 0
- rsp_rdata_o = 0
- rsp_illegal_o = 0
- mscratch = 0
- cycle counter = 0
REQ-030 Reset SHALL take priority over every other event; a pending response SHALL be discarded when reset is asserted in RESP.

Verification
REQ-031 Read misa with default parameters -> rsp_rdata_o=0x40101104 (1074794756), rsp_illegal_o=0; with RV32E=1, RV32M=0, MXL=1 -> 0x40100014.
REQ-032 Write mscratch 0xDEADBEEF, then set 0x0000F000, then clear 0x000000FF, then read -> responses 0, 0xDEADBEEF, 0xDEADFEEF; final read 0xDEADFE00.
REQ-033 Write mcycle 0xFFFFFFFF with mcycleh 0, wait 1 cycle, read mcycleh -> 1 (carry).
REQ-034 Write 0x123 to mhartid (0xF14) and read 0x7C0 -> rsp_illegal_o=1, rdata 0, no state change.
REQ-035 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o=0; assert rsp_ready_i -> IDLE on the next cycle.
REQ-036 Assert rst_ni=0 in RESP -> next cycle rsp_valid_o=0, req_ready_o=1 after release, mscratch=0.
